rst_mgr: RTL

Parametrised reset manager generating sequenced, per-domain synchronous reset outputs for the SoC. Stretches power-on reset, accepts a debounced board-button request, a one-cycle software request from the CPU, and optionally a CPU trap as reset sources. Deasserts resets domain by domain in a fixed order and records the cause of the last reset. It sits in the FPGA top level between the board clock/reset pins and the `system` instance.

---
 rtl/rst_mgr_pkg.sv | 38 +++
 rtl/rst_mgr_debounce.sv | 55 +++++
 rtl/rst_mgr.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rst_mgr_pkg.sv
// -----------------------------------------------------------------------------
// rst_mgr_pkg
// Shared definitions for the reset manager: sequencer state encodings, reset
// cause codes and the cause priority encoder.
// -----------------------------------------------------------------------------
package rst_mgr_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RST_HOLD    = 2'd0,
        RST_RELEASE = 2'd1,
        RST_RUN     = 2'd2
    } rst_state_e;

    // Reset cause codes reported on the cause output
    localparam logic [1:0] RST_CAUSE_POR  = 2'd0;
    localparam logic [1:0] RST_CAUSE_EXT  = 2'd1;
    localparam logic [1:0] RST_CAUSE_SW   = 2'd2;
    localparam logic [1:0] RST_CAUSE_TRAP = 2'd3;

    // Priority encoder for simultaneous requests: EXT > TRAP > SW
    function automatic logic [1:0] sel_cause(input logic ext_req,
                                             input logic trap_req,
                                             input logic sw_req);
        logic [1:0] c;
        if (ext_req) begin
            c = RST_CAUSE_EXT;
        end else if (trap_req) begin
            c = RST_CAUSE_TRAP;
        end else if (sw_req) begin
            c = RST_CAUSE_SW;
        end else begin
            c = RST_CAUSE_POR;
        end
        return c;
    endfunction

endpackage

// File: rtl/rst_mgr_debounce.sv
// -----------------------------------------------------------------------------
// rst_mgr_debounce
// Two-flop synchroniser followed by a stability filter. The clean level only
// changes after the synchronised input has held its new value for DEB_CNT
// consecutive cycles; any shorter excursion restarts the count.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   asynchronous raw input
//   dout     out  debounced, registered level
// -----------------------------------------------------------------------------
module rst_mgr_debounce #(
    parameter int DEB_CNT = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int DW = $clog2(DEB_CNT + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [DW-1:0] cnt_r;

    // Synchroniser and stability counter; count is cleared whenever the input agrees with the level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                // This sample is the DEB_CNT-th consecutive differing one
                if (cnt_r == DW'(DEB_CNT - 1)) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r   <= cnt_r + DW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign dout = level_r;

endmodule

// File: rtl/rst_mgr.sv
// -----------------------------------------------------------------------------
// rst_mgr
// Reset manager: stretches power-on reset, accepts a debounced board button,
// a single-cycle software request and (optionally) a CPU trap, then releases
// N_CH domain resets one by one (bit 0 first) and records the last cause.
//
// Optional feature macro: RSTMGR_TRAP_RST_EN
//   defined   -> trap high is a reset request (cause 3)
//   undefined -> trap is ignored
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low power-on reset
//   ext_rst_req  in   asynchronous board button, active high
//   sw_rst_req   in   synchronous single-cycle software reset pulse
//   trap         in   CPU trap level
//   rst_o        out  active-high domain resets, bit 0 released first
//   done         out  high once every domain is released
//   cause        out  last reset cause (0 POR, 1 EXT, 2 SW, 3 TRAP)
// -----------------------------------------------------------------------------
module rst_mgr
    import rst_mgr_pkg::*;
#(
    parameter int                 N_CH      = 2,
    parameter int                 CNT_W     = 16,
    parameter logic [CNT_W-1:0]   HOLD_CNT  = 16'hFFFF,
    parameter int                 STAGE_DLY = 16,
    parameter int                 DEB_CNT   = 1000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ext_rst_req,
    input  logic            sw_rst_req,
    input  logic            trap,
    output logic [N_CH-1:0] rst_o,
    output logic            done,
    output logic [1:0]      cause
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    rst_state_e       state_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0] stage_cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [N_CH-1:0]  rst_r;
    logic             done_r;
    logic [1:0]       cause_r;

    logic             ext_deb_s;
    logic             trap_req_s;
    logic             req_s;

    rst_mgr_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ext_rst_req),
        .dout    (ext_deb_s)
    );

`ifdef RSTMGR_TRAP_RST_EN
    assign trap_req_s = trap;
`else
    // Trap is not a reset source in this build; the AND keeps the pin referenced
    assign trap_req_s = 1'b0 & trap;
`endif

    // Any enabled source forces the sequence back to HOLD
    always_comb begin
        req_s = ext_deb_s | trap_req_s | sw_rst_req;
    end

    // Reset sequencer: hold, staged release, run; level requests reload every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RST_HOLD;
            hold_cnt_r  <= HOLD_CNT;
            stage_cnt_r <= '0;
            idx_r       <= '0;
            rst_r       <= '1;
            done_r      <= 1'b0;
            cause_r     <= RST_CAUSE_POR;
        end else if (req_s) begin
            state_r     <= RST_HOLD;
            hold_cnt_r  <= HOLD_CNT;
            stage_cnt_r <= '0;
            idx_r       <= '0;
            rst_r       <= '1;
            done_r      <= 1'b0;
            cause_r     <= sel_cause(ext_deb_s, trap_req_s, sw_rst_req);
        end else begin
            case (state_r)
                RST_HOLD: begin
                    if (hold_cnt_r == '0) begin
                        rst_r[0] <= 1'b0;
                        if (N_CH == 1) begin
                            state_r <= RST_RUN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= RST_RELEASE;
                            idx_r       <= IDX_W'(1);
                            stage_cnt_r <= CNT_W'(STAGE_DLY - 1);
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r - CNT_W'(1);
                    end
                end
                RST_RELEASE: begin
                    if (stage_cnt_r == '0) begin
                        rst_r[idx_r] <= 1'b0;
                        if (idx_r == IDX_W'(N_CH - 1)) begin
                            state_r <= RST_RUN;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r       <= idx_r + IDX_W'(1);
                            stage_cnt_r <= CNT_W'(STAGE_DLY - 1);
                        end
                    end else begin
                        stage_cnt_r <= stage_cnt_r - CNT_W'(1);
                    end
                end
                RST_RUN: begin
                    state_r <= RST_RUN;
                end
                default: begin
                    // Unreachable encoding: restart a full sequence
                    state_r    <= RST_HOLD;
                    hold_cnt_r <= HOLD_CNT;
                    rst_r      <= '1;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign rst_o = rst_r;
    assign done  = done_r;
    assign cause = cause_r;

endmodule
